i2s_line_in: RTL



---
 rtl/i2s_line_in.sv | 137 +++++++++++++
 1 files changed

// File: rtl/i2s_line_in.sv
// i2s_line_in: I2S capture front-end for the line-in (ADC) side of the Pmod I2S2.
// Derives MCLK (clk/4), SCLK (clk/32) and LRCK (clk/2048) from the 100 MHz
// system clock with the same frame geometry as the DAC output path. It
// deserialises the ADC data MSB-first into signed left/right samples and
// presents each stereo frame on a valid/ready handshake with a sticky overrun flag.
// Optional feature: define I2S_LINE_IN_MONO_EN to add mono_sample = (l + r) >>> 1.
module i2s_line_in #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  input  logic                sdout,
  output logic [SAMPLE_W-1:0] l_sample,
  output logic [SAMPLE_W-1:0] r_sample,
`ifdef I2S_LINE_IN_MONO_EN
  output logic [SAMPLE_W-1:0] mono_sample,
`endif
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                clr_overrun
);

  localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_W);

  logic [10:0]         cnt;
  logic [10:0]         cnt_nxt;
  logic [4:0]          slot;
  logic                sample_pt;
  logic                data_slot;
  logic                left_done;
  logic                frame_done;
  logic                sync_q1;
  logic                sync_q2;
  logic [SAMPLE_W-1:0] shift_q;
  logic [SAMPLE_W-1:0] shift_nxt;
  logic [SAMPLE_W-1:0] left_hold;

  assign cnt_nxt = cnt + 11'd1;
  assign slot    = cnt[9:5];

  // Two clk after the SCLK rising edge, so the bit has cleared the synchroniser.
  assign sample_pt  = (cnt[4:0] == 5'd18);
  // Slot 0 is the I2S delay bit; slots past the last data bit are padding.
  assign data_slot  = (slot != 5'd0) && (slot <= LAST_SLOT);
  assign left_done  = sample_pt && (slot == LAST_SLOT) && !cnt[10];
  assign frame_done = sample_pt && (slot == LAST_SLOT) &&  cnt[10];

  // Shift in the synchronised bit; the cast drops the oldest bit off the top.
  assign shift_nxt = SAMPLE_W'({shift_q, sync_q2});

`ifdef I2S_LINE_IN_MONO_EN
  logic signed [SAMPLE_W:0] mono_sum;
  // One extra bit of headroom so full-scale l + r cannot wrap before the halving.
  assign mono_sum = $signed({left_hold[SAMPLE_W-1], left_hold})
                  + $signed({shift_nxt[SAMPLE_W-1], shift_nxt});
`endif

  // Free-running frame counter; the clock outputs are registered copies of its
  // bits, taken from the next-count value so they stay in phase with cnt.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; blocking assignments here would create order-dependent
    // races between these signals.
    if (rst) begin
      cnt  <= '0;
      mclk <= 1'b0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      mclk <= cnt_nxt[1];
      sclk <= cnt_nxt[4];
      lrck <= cnt_nxt[10];
    end
  end

  // Two-flop synchroniser for the pad-level ADC data.
  always_ff @(posedge clk) begin
    // NOTE: the synchroniser and datapath registers are reset as well, so a
    // partially received frame never leaks into the first frame after reset.
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sdout;
      sync_q2 <= sync_q1;
    end
  end

  // Deserialiser: shift on each data slot and park the finished left word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      left_hold <= '0;
    end else begin
      if (sample_pt && data_slot) shift_q <= shift_nxt;
      if (left_done)              left_hold <= shift_nxt;
    end
  end

  // Output frame register, valid/ready handshake and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_sample     <= '0;
      r_sample     <= '0;
`ifdef I2S_LINE_IN_MONO_EN
      mono_sample  <= '0;
`endif
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_done) begin
        // Newest frame always wins, even over one still waiting for a consumer.
        l_sample     <= left_hold;
        r_sample     <= shift_nxt;
`ifdef I2S_LINE_IN_MONO_EN
        mono_sample  <= SAMPLE_W'(mono_sum >>> 1);
`endif
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      // Setting takes priority so a clear cannot hide a simultaneous loss.
      if (frame_done && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
